// File: rtl/ga_resp_unpacker.sv
// ga_resp_unpacker: buffers GA coprocessor responses and streams each result to the core as NW words
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   resp_i / resp_ready_o           response beats from the GA unit and the FIFO-not-full ready
//   word_valid_o / word_ready_i     output word stream handshake
//   word_data_o, word_idx_o         current word and its index within the response (word 0 = top bits)
//   word_last_o, word_err_o         final word of the response / response carried error
//   flush_i                         discards all buffered and in-flight data
//   err_clear_i                     clears the sticky flags (a coincident push still sets them)
//   err_sticky_o, ovf_sticky_o, udf_sticky_o  sticky status from pushed responses
//   busy_o                          FIFO non-empty
package ga_pkg;
  localparam int GA_MV_SIZE = 512;
  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [GA_MV_SIZE-1:0] result;
    logic                  error;
    logic                  overflow;
    logic                  underflow;
  } ga_resp_t;
endpackage

module ga_resp_unpacker
  import ga_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WORD_W = 32,
  localparam int NW = GA_MV_SIZE / WORD_W,
  localparam int IW = $clog2(NW)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ga_resp_t          resp_i,
  output logic              resp_ready_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [IW-1:0]     word_idx_o,
  output logic              word_last_o,
  output logic              word_err_o,
  input  logic              flush_i,
  input  logic              err_clear_i,
  output logic              err_sticky_o,
  output logic              ovf_sticky_o,
  output logic              udf_sticky_o,
  output logic              busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW-1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_d;
  logic [GA_MV_SIZE-1:0] mem_result [DEPTH];
  logic [DEPTH-1:0] mem_err, mem_ovf, mem_udf;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_d;
  logic [IW-1:0] cnt;
  logic [GA_MV_SIZE-1:0] head;
  logic push, hs, pop, head_err;
  logic unused;
  assign unused = ^{resp_i.ready, mem_ovf, mem_udf};
  assign resp_ready_o = count != FULL;
  assign busy_o = count != '0;
  assign push = resp_i.valid && resp_ready_o && !flush_i;
  assign head = mem_result[rd_ptr];
  assign head_err = mem_err[rd_ptr];
  // Outputs are gated by word_valid_o so the unreset FIFO storage never leaks out after reset.
  assign word_valid_o = state == STREAM;
  assign word_idx_o = cnt;
  assign word_last_o = word_valid_o && (head_err || cnt == LAST_IDX);
  assign word_err_o = word_valid_o && head_err;
  assign word_data_o = (word_valid_o && !head_err) ? head[(NW-1-int'(cnt))*WORD_W +: WORD_W] : '0;
  assign hs = word_valid_o && word_ready_i;
  assign pop = hs && word_last_o;
  // STREAM tracks the next-cycle occupancy, giving one-cycle push-to-valid and no bubble between entries.
  always_comb begin
    count_d = flush_i ? '0 : (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    state_d = (count_d != '0) ? STREAM : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      err_sticky_o <= 1'b0;
      ovf_sticky_o <= 1'b0;
      udf_sticky_o <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      wr_ptr <= flush_i ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush_i ? '0 : rd_ptr + AW'(pop);
      cnt <= (flush_i || pop) ? '0 : cnt + IW'(hs);
      err_sticky_o <= (err_sticky_o && !err_clear_i) || (push && resp_i.error);
      ovf_sticky_o <= (ovf_sticky_o && !err_clear_i) || (push && resp_i.overflow);
      udf_sticky_o <= (udf_sticky_o && !err_clear_i) || (push && resp_i.underflow);
    end
  always_ff @(posedge clk_i)
    if (push) begin
      mem_result[wr_ptr] <= resp_i.result;
      mem_err[wr_ptr] <= resp_i.error;
      mem_ovf[wr_ptr] <= resp_i.overflow;
      mem_udf[wr_ptr] <= resp_i.underflow;
    end
endmodule

// File: tb/tb_ga_resp_unpacker.sv
// tb_ga_resp_unpacker: randomized self-checking bench for ga_resp_unpacker against a word-stream model
module tb_ga_resp_unpacker;
  import ga_pkg::*;
  typedef struct packed {logic [31:0] d; logic [3:0] i; logic l; logic e;} w_t;
  logic clk_i = 0, rst_i = 1, word_ready_i = 0, flush_i = 0, err_clear_i = 0;
  ga_resp_t resp_i = '0;
  logic resp_ready_o, word_valid_o, word_last_o, word_err_o;
  logic err_sticky_o, ovf_sticky_o, udf_sticky_o, busy_o;
  logic [31:0] word_data_o;
  logic [3:0] word_idx_o;
  int cyc = 0, checks = 0, passed = 0, acc_cyc = 0;
  w_t exp_q[$], obs_q[$], hold_q[$];
  int stamp_q[$];
  logic m_err = 0, m_ovf = 0, m_udf = 0;

  ga_resp_unpacker dut (
    .clk_i(clk_i), .rst_i(rst_i), .resp_i(resp_i), .resp_ready_o(resp_ready_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .word_data_o(word_data_o),
    .word_idx_o(word_idx_o), .word_last_o(word_last_o), .word_err_o(word_err_o),
    .flush_i(flush_i), .err_clear_i(err_clear_i), .err_sticky_o(err_sticky_o),
    .ovf_sticky_o(ovf_sticky_o), .udf_sticky_o(udf_sticky_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic w_t cur();
    return {word_data_o, word_idx_o, word_last_o, word_err_o};
  endfunction

  function automatic logic [511:0] rnd_mv();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // An error response is a single zero word; otherwise sixteen words, most significant first.
  function automatic void model_add(input logic [511:0] r, input logic e);
    if (e) exp_q.push_back({32'd0, 4'd0, 1'b1, 1'b1});
    else for (int k = 0; k < 16; k++) exp_q.push_back({32'(r >> (32*(15-k))), 4'(k), k == 15, 1'b0});
  endfunction

  task automatic push(input logic [511:0] r, input logic e, input logic o, input logic u);
    int g = 0;
    resp_i.valid = 1; resp_i.result = r; resp_i.error = e; resp_i.overflow = o; resp_i.underflow = u;
    while (!resp_ready_o && g < 2000) begin tick(); g++; end
    acc_cyc = cyc;
    checks++;
    if (g >= 2000) $display("FAIL push_wait: resp_ready_o stuck at %b", resp_ready_o); else passed++;
    tick();
    resp_i.valid = 0;
    model_add(r, e);
    if (err_clear_i) begin m_err = e; m_ovf = o; m_udf = u; end
    else begin m_err |= e; m_ovf |= o; m_udf |= u; end
  endtask

  task automatic collect(input int n, input int stall_idx, input int stall_len, input bit rnd);
    int g = 0, st = 0;
    obs_q.delete(); hold_q.delete(); stamp_q.delete();
    while (obs_q.size() < n && g < 5000) begin
      word_ready_i = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (word_valid_o && int'(word_idx_o) == stall_idx && st < stall_len) begin
        word_ready_i = 0; st++; hold_q.push_back(cur());
      end
      if (word_valid_o && word_ready_i) begin obs_q.push_back(cur()); stamp_q.push_back(cyc); end
      tick(); g++;
    end
    word_ready_i = 0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({resp_ready_o, word_valid_o, word_last_o, word_err_o, err_sticky_o, ovf_sticky_o, udf_sticky_o, busy_o, word_data_o, word_idx_o} !== {1'b1, 43'd0})
      $display("FAIL reset_hold: got rdy=%b vld=%b busy=%b data=%h", resp_ready_o, word_valid_o, busy_o, word_data_o);
    else passed++;
    rst_i = 0;
    tick();
    checks++;
    if ({resp_ready_o, word_valid_o, busy_o} !== 3'b100) $display("FAIL reset_release: got %b want 100", {resp_ready_o, word_valid_o, busy_o}); else passed++;
  endtask

  task automatic test_single();
    logic [511:0] r;
    w_t x;
    for (int k = 0; k < 16; k++) r[511-32*k -: 32] = 32'hA000_0000 + 32'(k);
    push(r, 0, 0, 0);
    checks++;
    if (word_valid_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL single_latency: vld=%b busy=%b want 1 1", word_valid_o, busy_o); else passed++;
    collect(16, -1, 0, 0);
    checks++;
    if (obs_q.size() != 16) $display("FAIL single_count: got %0d want 16", obs_q.size()); else passed++;
    for (int k = 0; k < 16; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL single_word%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
    checks++;
    if (stamp_q.size() != 16 || stamp_q[15] - stamp_q[0] != 15) $display("FAIL single_rate: span %0d want 15", stamp_q[stamp_q.size()-1] - stamp_q[0]); else passed++;
    checks++;
    if (busy_o !== 1'b0 || word_valid_o !== 1'b0) $display("FAIL single_busy_fall: busy=%b vld=%b want 0 0", busy_o, word_valid_o); else passed++;
  endtask

  task automatic test_backpressure();
    logic [511:0] r;
    w_t x, w5;
    for (int k = 0; k < 16; k++) r[511-32*k -: 32] = 32'hA000_0000 + 32'(k);
    push(r, 0, 0, 0);
    w5 = exp_q[5];
    collect(16, 5, 3, 0);
    checks++;
    if (hold_q.size() != 3) $display("FAIL bp_stall_len: got %0d want 3", hold_q.size()); else passed++;
    for (int j = 0; j < hold_q.size(); j++) begin
      checks++;
      if (hold_q[j] !== w5) $display("FAIL bp_hold%0d: got %h want %h", j, hold_q[j], w5); else passed++;
    end
    checks++;
    if (obs_q.size() != 16) $display("FAIL bp_count: got %0d want 16", obs_q.size()); else passed++;
    for (int k = 0; k < 16; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL bp_word%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
  endtask

  task automatic test_full();
    logic [511:0] r3;
    w_t x;
    r3 = rnd_mv();
    word_ready_i = 0;
    push(rnd_mv(), 0, 0, 0);
    push(rnd_mv(), 0, 0, 0);
    checks++;
    if (resp_ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", resp_ready_o); else passed++;
    resp_i.valid = 1; resp_i.result = r3; resp_i.error = 0; resp_i.overflow = 0; resp_i.underflow = 0;
    repeat (3) tick();
    checks++;
    if (resp_ready_o !== 1'b0 || word_idx_o !== 4'd0 || word_valid_o !== 1'b1) $display("FAIL full_hold: rdy=%b idx=%0d vld=%b", resp_ready_o, word_idx_o, word_valid_o); else passed++;
    fork
      push(r3, 0, 0, 0);
      collect(48, -1, 0, 0);
    join
    checks++;
    if (obs_q.size() != 48) $display("FAIL full_count: got %0d want 48", obs_q.size()); else passed++;
    for (int k = 0; k < 48; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL full_word%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
    checks++;
    if (stamp_q.size() != 48 || acc_cyc != stamp_q[15] + 1) $display("FAIL full_ready_rise: accept at %0d want %0d", acc_cyc, stamp_q[15] + 1); else passed++;
    checks++;
    if (stamp_q.size() != 48 || stamp_q[47] - stamp_q[0] != 47) $display("FAIL full_bubble: span %0d want 47", stamp_q[stamp_q.size()-1] - stamp_q[0]); else passed++;
  endtask

  task automatic test_error();
    w_t x;
    push(rnd_mv(), 1, 1, 0);
    checks++;
    if ({err_sticky_o, ovf_sticky_o, udf_sticky_o} !== {m_err, m_ovf, m_udf}) $display("FAIL err_sticky_set: got %b want %b", {err_sticky_o, ovf_sticky_o, udf_sticky_o}, {m_err, m_ovf, m_udf}); else passed++;
    push(rnd_mv(), 0, 0, 0);
    collect(17, -1, 0, 0);
    checks++;
    if (obs_q.size() != 17) $display("FAIL err_count: got %0d want 17", obs_q.size()); else passed++;
    for (int k = 0; k < 17; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL err_word%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
    checks++;
    if ({err_sticky_o, ovf_sticky_o, udf_sticky_o} !== {m_err, m_ovf, m_udf}) $display("FAIL err_sticky_keep: got %b want %b", {err_sticky_o, ovf_sticky_o, udf_sticky_o}, {m_err, m_ovf, m_udf}); else passed++;
    err_clear_i = 1; tick(); err_clear_i = 0;
    m_err = 0; m_ovf = 0; m_udf = 0;
    checks++;
    if ({err_sticky_o, ovf_sticky_o, udf_sticky_o} !== 3'b000) $display("FAIL err_clear: got %b want 000", {err_sticky_o, ovf_sticky_o, udf_sticky_o}); else passed++;
    err_clear_i = 1;
    push(rnd_mv(), 1, 0, 1);
    err_clear_i = 0;
    checks++;
    if ({err_sticky_o, ovf_sticky_o, udf_sticky_o} !== {m_err, m_ovf, m_udf}) $display("FAIL err_clear_vs_push: got %b want %b", {err_sticky_o, ovf_sticky_o, udf_sticky_o}, {m_err, m_ovf, m_udf}); else passed++;
    collect(1, -1, 0, 0);
    x = exp_q.pop_front();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== x) $display("FAIL err_single: got %h want %h", obs_q[0], x); else passed++;
  endtask

  task automatic test_flush();
    w_t x;
    push(rnd_mv(), 0, 0, 0);
    push(rnd_mv(), 0, 0, 0);
    collect(7, -1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL flush_pre%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
    checks++;
    if (word_valid_o !== 1'b1 || word_idx_o !== 4'd7) $display("FAIL flush_at7: vld=%b idx=%0d want 1 7", word_valid_o, word_idx_o); else passed++;
    flush_i = 1; tick(); flush_i = 0;
    exp_q.delete();
    checks++;
    if ({word_valid_o, busy_o, resp_ready_o, word_idx_o} !== {3'b001, 4'd0}) $display("FAIL flush_empty: vld=%b busy=%b rdy=%b idx=%0d", word_valid_o, busy_o, resp_ready_o, word_idx_o); else passed++;
    flush_i = 1;
    resp_i.valid = 1; resp_i.result = rnd_mv(); resp_i.error = 1; resp_i.overflow = 1; resp_i.underflow = 1;
    tick();
    flush_i = 0; resp_i.valid = 0;
    checks++;
    if ({busy_o, word_valid_o, err_sticky_o, ovf_sticky_o, udf_sticky_o} !== {2'b00, m_err, m_ovf, m_udf}) $display("FAIL flush_drop: got %b want %b", {busy_o, word_valid_o, err_sticky_o, ovf_sticky_o, udf_sticky_o}, {2'b00, m_err, m_ovf, m_udf}); else passed++;
    push(rnd_mv(), 0, 0, 0);
    collect(16, -1, 0, 0);
    checks++;
    if (obs_q.size() != 16) $display("FAIL flush_after_count: got %0d want 16", obs_q.size()); else passed++;
    for (int k = 0; k < 16; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL flush_after%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] rs[8];
    logic es[8], os[8], us[8];
    int total = 0;
    w_t x;
    err_clear_i = 1; tick(); err_clear_i = 0;
    m_err = 0; m_ovf = 0; m_udf = 0;
    for (int i = 0; i < 8; i++) begin
      rs[i] = rnd_mv();
      es[i] = ($urandom_range(3) == 0);
      os[i] = ($urandom_range(3) == 0);
      us[i] = ($urandom_range(3) == 0);
      total += es[i] ? 1 : 16;
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(2)) tick();
          push(rs[i], es[i], os[i], us[i]);
        end
      end
      collect(total, -1, 0, 1);
    join
    checks++;
    if (obs_q.size() != total) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), total); else passed++;
    for (int k = 0; k < total; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL b2b_word%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
    checks++;
    if ({err_sticky_o, ovf_sticky_o, udf_sticky_o, busy_o} !== {m_err, m_ovf, m_udf, 1'b0}) $display("FAIL b2b_sticky: got %b want %b", {err_sticky_o, ovf_sticky_o, udf_sticky_o, busy_o}, {m_err, m_ovf, m_udf, 1'b0}); else passed++;
  endtask

  task automatic test_reset_mid();
    w_t x;
    push(rnd_mv(), 0, 0, 1);
    collect(4, -1, 0, 0);
    exp_q.delete();
    checks++;
    if (udf_sticky_o !== 1'b1 || word_valid_o !== 1'b1) $display("FAIL rst_pre: udf=%b vld=%b want 1 1", udf_sticky_o, word_valid_o); else passed++;
    rst_i = 1;
    #1;
    checks++;
    if ({resp_ready_o, word_valid_o, word_last_o, word_err_o, err_sticky_o, ovf_sticky_o, udf_sticky_o, busy_o, word_data_o, word_idx_o} !== {1'b1, 43'd0})
      $display("FAIL rst_async: got rdy=%b vld=%b busy=%b udf=%b idx=%0d data=%h", resp_ready_o, word_valid_o, busy_o, udf_sticky_o, word_idx_o, word_data_o);
    else passed++;
    tick();
    rst_i = 0;
    m_err = 0; m_ovf = 0; m_udf = 0;
    push(rnd_mv(), 0, 0, 0);
    collect(16, -1, 0, 0);
    checks++;
    if (obs_q.size() != 16) $display("FAIL rst_after_count: got %0d want 16", obs_q.size()); else passed++;
    for (int k = 0; k < 16; k++) begin
      x = exp_q.pop_front();
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== x) $display("FAIL rst_after%0d: got %h want %h", k, obs_q[k], x); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_error();
    test_flush();
    for (int n = 0; n < 3; n++) test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ga_resp_unpacker.md
# ga_resp_unpacker

Core-side receiver for the GA coprocessor response channel. It accepts `ga_resp_t` beats from the GA unit and buffers them in a small FIFO. It returns each 512-bit multivector result to the integer core as sixteen 32-bit words over a valid/ready stream. It also tracks sticky error, overflow and underflow status for the core's CSR logic.

## Interface

**Parameters**
- `DEPTH`, default 2: number of response entries buffered. Must be a power of two, ≥ 2.
- `WORD_W`, default 32: output word width. `GA_MV_SIZE` must be divisible by `WORD_W`.

**Ports** (`NW = GA_MV_SIZE/WORD_W`, 16 at defaults)
- `clk_i` input 1: clock. Single clock domain.
- `rst_i` input 1: reset, asynchronous, active-high.
- `resp_i` input `ga_resp_t`: response from the GA unit. Only `valid`, `result`, `error`, `overflow` and `underflow` are consumed.
- `resp_ready_o` output 1: high when the FIFO can accept a response. Drives the `ready` field back to the GA unit.
- `word_valid_o` output 1: an output word is presented.
- `word_ready_i` input 1: the core accepts the word.
- `word_data_o` output `WORD_W`: result word.
- `word_idx_o` output `$clog2(NW)`: word index within the current response.
- `word_last_o` output 1: final word of the current response.
- `word_err_o` output 1: the current response carried `error`.
- `flush_i` input 1: synchronous discard of all buffered and in-flight data.
- `err_clear_i` input 1: clears the sticky flags.
- `err_sticky_o`, `ovf_sticky_o`, `udf_sticky_o` output 1 each: sticky status flags.
- `busy_o` output 1: the FIFO is non-empty.

## Operation

**Accept**
- A push occurs when `resp_i.valid && resp_ready_o && !flush_i`.
- Each entry stores `result`, `error`, `overflow` and `underflow`.
- `resp_ready_o = (count != DEPTH)`, taken from registered count only. There is no same-cycle bypass: when the FIFO is full, a pop in the same cycle does not enable a push.
- `resp_i` is ignored when `resp_i.valid` is 0.

**State machine** (head entry)
- `IDLE`
  - Condition: FIFO empty. `word_valid_o` = 0.
  - Transition: to `STREAM` the cycle after the FIFO becomes non-empty.
- `STREAM`, head `error` = 0
  - Word k (k = 0 … NW−1) = `result[GA_MV_SIZE-1-k*WORD_W -: WORD_W]`. Word 0 carries `scalar` in bits [31:16] and `e1` in bits [15:0].
  - `word_idx_o` = k; `word_last_o` = (k == NW−1); `word_err_o` = 0.
  - The 4-bit word counter increments on each handshake.
- `STREAM`, head `error` = 1
  - Emits exactly one word: `word_data_o` = 0, `word_idx_o` = 0, `word_last_o` = 1, `word_err_o` = 1.
- On the handshake of the last word:
  - The head entry is popped and the counter wraps to 0.
  - Next state is `STREAM` if another entry remains, otherwise `IDLE`.

**Stream rules**
- While `word_valid_o && !word_ready_i`, all `word_*` outputs hold stable.
- `word_valid_o` never deasserts without a handshake, except on `flush_i` or reset.

**Sticky flags**
- On each push, the entry's `error`, `overflow` and `underflow` bits are ORed into the matching flag.
- `err_clear_i` zeroes all three flags. If a push occurs in the same cycle, the pushed bits win (set priority).

**Flush**
- `flush_i` empties the FIFO, zeroes the word counter and returns the FSM to `IDLE`.
- A push in the same cycle is dropped.
- Sticky flags are unaffected.

**Reset**
- All outputs are 0 except `resp_ready_o` = 1 (FIFO empty).
- Pointers, count and word counter are 0. FSM is in `IDLE`. Sticky flags are 0.
- Asserting reset mid-stream discards everything immediately.

## Timing

- Push to first word valid: 1 cycle when the FIFO was empty. All `word_*` outputs are registered or derived from registered state.
- Throughput: NW cycles per non-error response and 1 cycle per error response, with `word_ready_i` held high.
- Back-to-back responses: the first word of entry N+1 is valid in the cycle after the last handshake of entry N, with no bubble.
- `resp_ready_o` rises in the cycle after the pop that frees a slot.
- Sticky flags update in the cycle after the push.
- `busy_o` rises in the cycle after the push and falls in the cycle after the final pop.

## Test plan

- **Single response.** Push one response with `result` word k = 32'hA000_0000+k and `word_ready_i` = 1. Expect 16 words with idx 0…15 and data A000_0000…A000_000F in order. `word_last_o` is high only at idx 15. `busy_o` falls the next cycle.
- **Backpressure.** Same stimulus as above, but deassert `word_ready_i` for 3 cycles at idx 5. Expect data, idx and last held constant during the stall. The output stream must equal the single-response case exactly.
- **Full FIFO.** Hold `word_ready_i` = 0 and push 2 responses. Expect `resp_ready_o` = 0 and a third `resp_i.valid` not accepted. Raise `word_ready_i`. Expect `resp_ready_o` = 1 one cycle after the 16th handshake, and the third response streamed after the second with no bubbles.
- **Error response.** Push a response with `error` = 1 and `overflow` = 1, followed by a normal response. Expect one word with data 0, `word_err_o` = 1 and last = 1, then 16 normal words. `err_sticky_o` and `ovf_sticky_o` are 1 and remain 1 until `err_clear_i`. `err_clear_i` coincident with an error push leaves `err_sticky_o` = 1.
- **Flush and reset.** Assert `flush_i` at idx 7 with one further response queued. Expect `word_valid_o` = 0 and `busy_o` = 0 the next cycle, and a subsequent push starting at idx 0. Assert `rst_i` asynchronously mid-stream. Expect all outputs to go to 0 immediately, with `resp_ready_o` = 1.
